// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the 8080-style LCD bus receiver: command codes,
// decoder state encoding and a byte-join helper for window parameters.
package lcd_bus_pkg;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR,
    SKIP
  } rx_state_t;

  // Window parameters arrive high byte first; this rebuilds the 16-bit value.
  function automatic logic [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/lcd_bus_rx_addr_gen.sv
// Column/page window registers and the x/y pixel address counter.
// Wraps x inside the column window and y inside the page window; o_last
// flags the final pixel of the window so the top can raise frame_done.
module lcd_bus_rx_addr_gen
  import lcd_bus_pkg::*;
#(
  parameter int COORD_W = 9,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_colWr,
  input  logic               i_pageWr,
  input  logic [COORD_W-1:0] i_start,
  input  logic [COORD_W-1:0] i_end,
  input  logic               i_loadOrigin,
  input  logic               i_advance,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last
);

  logic [COORD_W-1:0] r_sc, r_ec, r_sp, r_ep;
  logic [COORD_W-1:0] r_x, r_y;

  // Window registers take a complete start/end pair only when a parameter set is finished.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sc <= '0;
      r_ec <= COORD_W'(X_MAX);
      r_sp <= '0;
      r_ep <= COORD_W'(Y_MAX);
    end else begin
      if (i_colWr) begin
        r_sc <= i_start;
        r_ec <= i_end;
      end
      if (i_pageWr) begin
        r_sp <= i_start;
        r_ep <= i_end;
      end
    end
  end

  // Raster-order address counter; >= compares keep an inverted window to one column/row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_loadOrigin) begin
      r_x <= r_sc;
      r_y <= r_sp;
    end else if (i_advance) begin
      if (r_x >= r_ec) begin
        r_x <= r_sc;
        if (r_y >= r_ep) begin
          r_y <= r_sp;
        end else begin
          r_y <= r_y + 1'b1;
        end
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x >= r_ec) && (r_y >= r_ep);

endmodule

// File: rtl/lcd_bus_rx.sv
// Receive endpoint of the 16-bit 8080-style LCD bus. Samples data/wr/rs
// through a uniform register chain, detects wr rising edges and decodes
// CASET/PASET/RAMWR/RAMWR-continue into an x/y tagged pixel stream.
// Optional statistics counters are built when LCD_BUS_RX_STATS_EN is defined.
module lcd_bus_rx
  import lcd_bus_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int COORD_W     = 9,
  parameter int SYNC_STAGES = 2,
  parameter int X_MAX       = 319,
  parameter int Y_MAX       = 239
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DATA_W-1:0]  lcd_data_i,
  input  logic               lcd_wr_i,
  input  logic               lcd_rd_i,
  input  logic               lcd_rs_i,
  output logic               pix_valid_o,
  output logic [DATA_W-1:0]  pix_data_o,
  output logic [COORD_W-1:0] pix_x_o,
  output logic [COORD_W-1:0] pix_y_o,
  output logic               frame_start_o,
  output logic               frame_done_o,
  output logic               cmd_valid_o,
`ifdef LCD_BUS_RX_STATS_EN
  output logic [15:0]        frame_cnt_o,
  output logic [31:0]        pix_cnt_o,
`endif
  output logic [7:0]         cmd_o
);

  localparam int SW = DATA_W + 2;

  logic [SW-1:0]      r_sync [SYNC_STAGES];
  logic               r_wrPrev;
  rx_state_t          r_state;
  logic [2:0]         r_paramIdx;
  logic [15:0]        r_shadowStart;
  logic [7:0]         r_shadowEndHi;

  logic [DATA_W-1:0]  w_data;
  logic [7:0]         w_byte;
  logic               w_wr, w_rs, w_wrEvt, w_cmdEvt, w_datEvt;
  logic               w_colCommit, w_pageCommit, w_loadOrigin, w_pixEvt;
  logic [COORD_W-1:0] w_start, w_end, w_x, w_y;
  logic               w_last;
  logic               w_unused;

  // Shared sampling chain so data, wr and rs always stay aligned with each other.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {lcd_wr_i, lcd_rs_i, lcd_data_i};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_wr   = r_sync[SYNC_STAGES-1][SW-1];
  assign w_rs   = r_sync[SYNC_STAGES-1][SW-2];
  assign w_data = r_sync[SYNC_STAGES-1][DATA_W-1:0];
  assign w_byte = w_data[7:0];

  // Previous wr value from the last stage, used for rising-edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_wrPrev <= 1'b0;
    else       r_wrPrev <= w_wr;
  end

  assign w_wrEvt      = w_wr & ~r_wrPrev;
  assign w_cmdEvt     = w_wrEvt & ~w_rs;
  assign w_datEvt     = w_wrEvt & w_rs;
  assign w_colCommit  = w_datEvt && (r_state == CASET) && (r_paramIdx == 3'd3);
  assign w_pageCommit = w_datEvt && (r_state == PASET) && (r_paramIdx == 3'd3);
  assign w_loadOrigin = w_cmdEvt && (w_byte == CMD_RAMWR);
  assign w_pixEvt     = w_datEvt && (r_state == RAMWR);
  assign w_start      = COORD_W'(r_shadowStart);
  assign w_end        = COORD_W'(join_bytes(r_shadowEndHi, w_byte));

  // Upper shadow bits beyond the coordinate width and the read strobe are intentionally unused.
  assign w_unused = ^{lcd_rd_i, r_shadowStart, r_shadowEndHi};

  lcd_bus_rx_addr_gen #(
    .COORD_W(COORD_W),
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX)
  ) u_addrGen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_colWr     (w_colCommit),
    .i_pageWr    (w_pageCommit),
    .i_start     (w_start),
    .i_end       (w_end),
    .i_loadOrigin(w_loadOrigin),
    .i_advance   (w_pixEvt),
    .o_x         (w_x),
    .o_y         (w_y),
    .o_last      (w_last)
  );

  // Decoder FSM with registered pulse outputs, one cycle after each detected write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_paramIdx    <= '0;
      r_shadowStart <= '0;
      r_shadowEndHi <= '0;
      pix_valid_o   <= 1'b0;
      pix_data_o    <= '0;
      pix_x_o       <= '0;
      pix_y_o       <= '0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      cmd_valid_o   <= 1'b0;
      cmd_o         <= '0;
    end else begin
      pix_valid_o   <= 1'b0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      cmd_valid_o   <= 1'b0;
      if (w_cmdEvt) begin
        cmd_valid_o <= 1'b1;
        cmd_o       <= w_byte;
        r_paramIdx  <= '0;
        case (w_byte)
          CMD_CASET:  r_state <= CASET;
          CMD_PASET:  r_state <= PASET;
          CMD_RAMWR: begin
            r_state       <= RAMWR;
            frame_start_o <= 1'b1;
          end
          CMD_RAMWRC: r_state <= RAMWR;
          default:    r_state <= SKIP;
        endcase
      end else if (w_datEvt) begin
        case (r_state)
          CASET, PASET: begin
            if (r_paramIdx != 3'd4) begin
              r_paramIdx <= r_paramIdx + 3'd1;
              case (r_paramIdx[1:0])
                2'd0:    r_shadowStart[15:8] <= w_byte;
                2'd1:    r_shadowStart[7:0]  <= w_byte;
                2'd2:    r_shadowEndHi       <= w_byte;
                default: ;
              endcase
            end
          end
          RAMWR: begin
            pix_valid_o  <= 1'b1;
            pix_data_o   <= w_data;
            pix_x_o      <= w_x;
            pix_y_o      <= w_y;
            frame_done_o <= w_last;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LCD_BUS_RX_STATS_EN
  // Free-running statistics: pixels since the last frame start and completed frames.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_cnt_o   <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (w_loadOrigin)  pix_cnt_o <= '0;
      else if (w_pixEvt) pix_cnt_o <= pix_cnt_o + 32'd1;
      if (w_pixEvt && w_last) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
`endif

endmodule
